// File: rtl/syn_pcm_buf_ctrl_if.sv
// syn_pcm_buf_ctrl_if: capture, host read-back and PCM RAM port bundle for syn_pcm_buf_ctrl.
interface syn_pcm_buf_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
);
    logic              capture_en_i;
    logic              pcm_valid_i;
    logic [DATA_W-1:0] pcm_ldata_i;
    logic [DATA_W-1:0] pcm_rdata_i;
    logic              host_rd_req_i;
    logic [ADDR_W:0]   host_rd_addr_i;
    logic              host_rd_ack_o;
    logic              host_rd_valid_o;
    logic [DATA_W-1:0] host_rd_data_o;
    logic [ADDR_W-1:0] lmem_addr_o;
    logic [ADDR_W-1:0] rmem_addr_o;
    logic [DATA_W-1:0] lmem_wdata_o;
    logic [DATA_W-1:0] rmem_wdata_o;
    logic              lmem_wren_o;
    logic              rmem_wren_o;
    logic              lmem_rden_o;
    logic              rmem_rden_o;
    logic [DATA_W-1:0] lmem_rdata_i;
    logic [DATA_W-1:0] rmem_rdata_i;
    logic              lmem_rd_valid_i;
    logic              rmem_rd_valid_i;
    logic              buf_rdy_o;
    logic              buf_sel_o;
    logic [CNT_W-1:0]  buf_cnt_o;
    logic              ovrflw_o;
    logic              ovrflw_clr_i;

    modport slave (
        input  capture_en_i, pcm_valid_i, pcm_ldata_i, pcm_rdata_i,
        input  host_rd_req_i, host_rd_addr_i, ovrflw_clr_i,
        input  lmem_rdata_i, rmem_rdata_i, lmem_rd_valid_i, rmem_rd_valid_i,
        output host_rd_ack_o, host_rd_valid_o, host_rd_data_o,
        output lmem_addr_o, rmem_addr_o, lmem_wdata_o, rmem_wdata_o,
        output lmem_wren_o, rmem_wren_o, lmem_rden_o, rmem_rden_o,
        output buf_rdy_o, buf_sel_o, buf_cnt_o, ovrflw_o
    );

    modport master (
        output capture_en_i, pcm_valid_i, pcm_ldata_i, pcm_rdata_i,
        output host_rd_req_i, host_rd_addr_i, ovrflw_clr_i,
        output lmem_rdata_i, rmem_rdata_i, lmem_rd_valid_i, rmem_rd_valid_i,
        input  host_rd_ack_o, host_rd_valid_o, host_rd_data_o,
        input  lmem_addr_o, rmem_addr_o, lmem_wdata_o, rmem_wdata_o,
        input  lmem_wren_o, rmem_wren_o, lmem_rden_o, rmem_rden_o,
        input  buf_rdy_o, buf_sel_o, buf_cnt_o, ovrflw_o
    );
endinterface

// File: rtl/syn_pcm_buf_ctrl.sv
// syn_pcm_buf_ctrl: Acortex-side PCM ping-pong RAM write sequencer with host read-back arbitration.
// The host read path and its FSM exist only when SYN_PCM_BUF_CTRL_HOST_RD_EN is defined.
module syn_pcm_buf_ctrl #(
    parameter int P_MEM_DATA_W = 32,
    parameter int P_MEM_ADDR_W = 7,
    parameter int P_RAM_RDELAY = 2,
    parameter int P_BUF_CNT_W  = 16
) (
    input logic               clk_ir,
    input logic               rst_ih,
    syn_pcm_buf_ctrl_if.slave bus
);
    logic                    pend;
    logic [P_MEM_DATA_W-1:0] pend_l;
    logic [P_MEM_DATA_W-1:0] pend_r;
    logic [P_MEM_ADDR_W-1:0] wr_ptr;
    logic                    buf_sel;
    logic                    buf_rdy;
    logic                    ovrflw;
    logic [P_BUF_CNT_W-1:0]  buf_cnt;
    logic                    load;
    logic                    wr;
    logic                    at_max;
    logic                    rd_issue;
    logic                    blocked;

    if (P_RAM_RDELAY < 1) begin : g_rdelay_chk
        $error("P_RAM_RDELAY must be at least 1");
    end

    assign load   = bus.pcm_valid_i & bus.capture_en_i;
    assign at_max = &wr_ptr;
    assign wr     = pend & ~blocked;

    always_ff @(posedge clk_ir or posedge rst_ih)
        if (rst_ih) begin
            pend    <= 1'b0;
            pend_l  <= '0;
            pend_r  <= '0;
            wr_ptr  <= '0;
            buf_sel <= 1'b0;
            buf_rdy <= 1'b0;
            buf_cnt <= '0;
            ovrflw  <= 1'b0;
        end else begin
            if (load & (~pend | wr)) begin
                pend_l <= bus.pcm_ldata_i;
                pend_r <= bus.pcm_rdata_i;
            end
            pend    <= load | (pend & ~wr);
            wr_ptr  <= wr_ptr + P_MEM_ADDR_W'(wr);
            buf_rdy <= wr & at_max;
            buf_sel <= buf_sel ^ (wr & at_max);
            buf_cnt <= buf_cnt + P_BUF_CNT_W'(wr & at_max);
            ovrflw  <= (load & pend & ~wr) | (ovrflw & ~bus.ovrflw_clr_i);
        end

    assign bus.lmem_wren_o   = wr;
    assign bus.rmem_wren_o   = wr;
    assign bus.lmem_wdata_o  = pend_l;
    assign bus.rmem_wdata_o  = pend_r;
    assign bus.lmem_addr_o   = rd_issue ? bus.host_rd_addr_i[P_MEM_ADDR_W-1:0] : wr_ptr;
    assign bus.rmem_addr_o   = rd_issue ? bus.host_rd_addr_i[P_MEM_ADDR_W-1:0] : wr_ptr;
    assign bus.lmem_rden_o   = rd_issue & ~bus.host_rd_addr_i[P_MEM_ADDR_W];
    assign bus.rmem_rden_o   = rd_issue & bus.host_rd_addr_i[P_MEM_ADDR_W];
    assign bus.host_rd_ack_o = rd_issue;
    assign bus.buf_rdy_o     = buf_rdy;
    assign bus.buf_sel_o     = buf_sel;
    assign bus.buf_cnt_o     = buf_cnt;
    assign bus.ovrflw_o      = ovrflw;

`ifdef SYN_PCM_BUF_CTRL_HOST_RD_EN
    typedef enum logic {IDLE, RD_WAIT} state_t;
    state_t                  state;
    state_t                  state_nx;
    logic                    rd_chan;
    logic                    rd_done;
    logic                    rd_valid;
    logic [P_MEM_DATA_W-1:0] rd_data;

    always_ff @(posedge clk_ir or posedge rst_ih)
        if (rst_ih) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = (state == IDLE) ? (rd_issue ? RD_WAIT : IDLE) : (rd_done ? IDLE : RD_WAIT);

    // A sample arriving this cycle also defers the read so the write always goes first.
    always_comb begin
        rd_issue = (state == IDLE) & bus.host_rd_req_i & ~pend & ~load;
        rd_done  = (state == RD_WAIT) & (rd_chan ? bus.rmem_rd_valid_i : bus.lmem_rd_valid_i);
        blocked  = (state == RD_WAIT) & at_max;
    end

    always_ff @(posedge clk_ir or posedge rst_ih)
        if (rst_ih) begin
            rd_chan  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (rd_issue) rd_chan <= bus.host_rd_addr_i[P_MEM_ADDR_W];
            if (rd_done) rd_data <= rd_chan ? bus.rmem_rdata_i : bus.lmem_rdata_i;
            rd_valid <= rd_done;
        end

    assign bus.host_rd_valid_o = rd_valid;
    assign bus.host_rd_data_o  = rd_data;
`else
    logic unused;

    assign rd_issue            = 1'b0;
    assign blocked             = 1'b0;
    assign bus.host_rd_valid_o = 1'b0;
    assign bus.host_rd_data_o  = '0;
    assign unused = ^{bus.host_rd_req_i, bus.lmem_rdata_i, bus.rmem_rdata_i,
                      bus.lmem_rd_valid_i, bus.rmem_rd_valid_i};
`endif
endmodule

// File: tb/tb_syn_pcm_buf_ctrl.sv
// tb_syn_pcm_buf_ctrl: randomized scoreboard bench for syn_pcm_buf_ctrl.
// Expected RAM writes and host read responses are queued by the drivers and retired by a monitor.
module tb_syn_pcm_buf_ctrl;
    localparam int DW    = 32;
    localparam int AW    = 7;
    localparam int CW    = 16;
    localparam int DEPTH = 1 << AW;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
    } wr_t;

    typedef struct {
        logic [AW:0] addr;
        int          ack_cyc;
    } rd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    syn_pcm_buf_ctrl_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    syn_pcm_buf_ctrl #(
        .P_MEM_DATA_W(DW), .P_MEM_ADDR_W(AW), .P_RAM_RDELAY(2), .P_BUF_CNT_W(CW)
    ) dut (
        .clk_ir(clk),
        .rst_ih(rst),
        .bus(bus)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          m_ptr    = 0;
    int          m_bufs   = 0;
    logic        exp_ovf  = 1'b0;
    wr_t         wr_q[$];
    logic [AW:0] req_q[$];
    rd_t         resp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
    endtask

    function automatic logic [DW-1:0] ram_word(input logic chan, input logic [AW-1:0] a);
        return {chan ? 16'hBEEF : 16'hCAFE, 9'd0, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic keep);
        bus.pcm_valid_i = 1'b1;
        bus.pcm_ldata_i = l;
        bus.pcm_rdata_i = r;
        if (keep) begin
            wr_q.push_back('{addr: AW'(m_ptr), l: l, r: r});
            if (m_ptr == DEPTH - 1) m_bufs++;
            m_ptr = (m_ptr + 1) % DEPTH;
        end
        tick();
        bus.pcm_valid_i = 1'b0;
    endtask

    task automatic host_read(input logic [AW:0] a);
        int n = 0;
        req_q.push_back(a);
        bus.host_rd_addr_i = a;
        bus.host_rd_req_i  = 1'b1;
        @(negedge clk);
        while (!bus.host_rd_ack_o && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!bus.host_rd_ack_o) begin
            failures++;
            $display("FAIL ack_timeout: addr %0h got ack 0 after 64 cycles, required 1", a);
            void'(req_q.pop_back());
        end
        tick();
        bus.host_rd_req_i = 1'b0;
    endtask

    // RAM model: read data appears two cycles after rden.
    initial begin
        logic d1l = 0, d1r = 0, d2l = 0, d2r = 0;
        logic [AW-1:0] a1 = '0, a2 = '0;
        bus.lmem_rd_valid_i = 1'b0;
        bus.rmem_rd_valid_i = 1'b0;
        bus.lmem_rdata_i    = '0;
        bus.rmem_rdata_i    = '0;
        forever begin
            @(negedge clk);
            bus.lmem_rd_valid_i = d2l;
            bus.rmem_rd_valid_i = d2r;
            bus.lmem_rdata_i    = d2l ? ram_word(1'b0, a2) : DW'($urandom);
            bus.rmem_rdata_i    = d2r ? ram_word(1'b1, a2) : DW'($urandom);
            d2l = d1l;
            d2r = d1r;
            a2  = a1;
            d1l = bus.lmem_rden_o;
            d1r = bus.rmem_rden_o;
            a1  = bus.rmem_rden_o ? bus.rmem_addr_o : bus.lmem_addr_o;
        end
    end

    initial begin
        wr_t         e;
        rd_t         r;
        logic [AW:0] a;
        logic        wrote_max;
        int          mon_ptr  = 0;
        int          mon_bufs = 0;
        logic        exp_rdy  = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                mon_ptr  = 0;
                mon_bufs = 0;
                exp_rdy  = 1'b0;
            end else begin
                wrote_max = 1'b0;
                chk("buf_rdy", bus.buf_rdy_o, exp_rdy);
                chk("buf_cnt", bus.buf_cnt_o, 64'(CW'(mon_bufs)));
                chk("buf_sel", bus.buf_sel_o, 64'(mon_bufs % 2));
                chk("ovrflw", bus.ovrflw_o, exp_ovf);
                if (bus.lmem_wren_o | bus.rmem_wren_o) begin
                    chk("ack_during_wr", bus.host_rd_ack_o, 0);
                    if (wr_q.size() == 0) flag("unexpected_wr", $sformatf("write to addr %0d with no sample owed", bus.lmem_addr_o));
                    else begin
                        e = wr_q.pop_front();
                        chk("wren_pair", {bus.lmem_wren_o, bus.rmem_wren_o}, 2'b11);
                        chk("wr_addr", {bus.lmem_addr_o, bus.rmem_addr_o}, {e.addr, e.addr});
                        chk("wr_ldata", bus.lmem_wdata_o, e.l);
                        chk("wr_rdata", bus.rmem_wdata_o, e.r);
                        wrote_max = (e.addr == AW'(DEPTH - 1));
                        mon_ptr   = (int'(e.addr) + 1) % DEPTH;
                    end
                end else if (bus.host_rd_ack_o) begin
                    if (req_q.size() == 0) flag("unexpected_ack", "ack with no request outstanding");
                    else begin
                        a = req_q.pop_front();
                        chk("rd_rden", {bus.lmem_rden_o, bus.rmem_rden_o}, {~a[AW], a[AW]});
                        chk("rd_addr", {bus.lmem_addr_o, bus.rmem_addr_o}, {a[AW-1:0], a[AW-1:0]});
                        resp_q.push_back('{addr: a, ack_cyc: cyc});
                    end
                end else begin
                    chk("idle_rden", {bus.lmem_rden_o, bus.rmem_rden_o}, 2'b00);
                    chk("idle_addr", {bus.lmem_addr_o, bus.rmem_addr_o}, {AW'(mon_ptr), AW'(mon_ptr)});
                end
                if (bus.host_rd_valid_o) begin
                    if (resp_q.size() == 0) flag("unexpected_rd_valid", "host_rd_valid_o with no read in flight");
                    else begin
                        r = resp_q.pop_front();
                        chk("rd_data", bus.host_rd_data_o, ram_word(r.addr[AW], r.addr[AW-1:0]));
                        chk("rd_latency", 64'(cyc - r.ack_cyc), 3);
                    end
                end
`ifndef SYN_PCM_BUF_CTRL_HOST_RD_EN
                chk("no_host_path", {bus.host_rd_ack_o, bus.host_rd_valid_o, bus.lmem_rden_o, bus.rmem_rden_o}, 4'h0);
                chk("no_host_data", bus.host_rd_data_o, 0);
`endif
                if (wrote_max) mon_bufs++;
                exp_rdy = wrote_max;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2ms");
        $fatal(1);
    end

    initial begin
        bus.capture_en_i   = 1'b1;
        bus.pcm_valid_i    = 1'b0;
        bus.pcm_ldata_i    = '0;
        bus.pcm_rdata_i    = '0;
        bus.host_rd_req_i  = 1'b0;
        bus.host_rd_addr_i = '0;
        bus.ovrflw_clr_i   = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("rst_wren", {bus.lmem_wren_o, bus.rmem_wren_o}, 0);
        chk("rst_rden", {bus.lmem_rden_o, bus.rmem_rden_o}, 0);
        chk("rst_ack_valid", {bus.host_rd_ack_o, bus.host_rd_valid_o}, 0);
        chk("rst_flags", {bus.buf_rdy_o, bus.buf_sel_o, bus.ovrflw_o}, 0);
        chk("rst_buf_cnt", bus.buf_cnt_o, 0);
        chk("rst_addr", {bus.lmem_addr_o, bus.rmem_addr_o}, 0);
        chk("rst_data", {bus.lmem_wdata_o, bus.rmem_wdata_o, bus.host_rd_data_o}, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            send(DW'(i), DW'(32'h1000 + i), 1'b1);
            repeat (3) tick();
        end
        repeat (3) tick();
        @(negedge clk);
        chk("first_buf_cnt", bus.buf_cnt_o, 64'(m_bufs));
        chk("first_buf_sel", bus.buf_sel_o, 64'(m_bufs % 2));
        chk("wrap_addr", bus.lmem_addr_o, 64'(m_ptr));
        tick();

`ifdef SYN_PCM_BUF_CTRL_HOST_RD_EN
        host_read(8'h85);
        repeat (6) tick();

        req_q.push_back(8'h13);
        bus.host_rd_addr_i = 8'h13;
        bus.host_rd_req_i  = 1'b1;
        bus.pcm_valid_i    = 1'b1;
        bus.pcm_ldata_i    = 32'hA5A5_0001;
        bus.pcm_rdata_i    = 32'h5A5A_0001;
        wr_q.push_back('{addr: AW'(m_ptr), l: 32'hA5A5_0001, r: 32'h5A5A_0001});
        m_ptr = (m_ptr + 1) % DEPTH;
        @(negedge clk);
        chk("simul_no_ack", bus.host_rd_ack_o, 0);
        tick();
        bus.pcm_valid_i = 1'b0;
        @(negedge clk);
        chk("simul_wr_first", {bus.lmem_wren_o, bus.host_rd_ack_o}, 2'b10);
        @(negedge clk);
        chk("simul_ack_next", bus.host_rd_ack_o, 1);
        tick();
        bus.host_rd_req_i = 1'b0;
        repeat (6) tick();

        while (m_ptr != DEPTH - 1) begin
            send(DW'($urandom), DW'($urandom), 1'b1);
            tick();
        end
        repeat (3) tick();
        host_read(8'h0A);
        send(32'h1111_007F, 32'h2222_007F, 1'b1);
        send(32'hDEAD_0000, 32'hDEAD_0001, 1'b0);
        exp_ovf = 1'b1;
        @(negedge clk);
        chk("held_wr_with_valid", {bus.lmem_wren_o, bus.host_rd_valid_o}, 2'b11);
        repeat (4) tick();
        bus.ovrflw_clr_i = 1'b1;
        tick();
        bus.ovrflw_clr_i = 1'b0;
        exp_ovf = 1'b0;
        tick();
`endif

        bus.capture_en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(DW'($urandom), DW'($urandom), 1'b0);
            tick();
        end
        bus.capture_en_i = 1'b1;
        @(negedge clk);
        chk("disabled_ovrflw", bus.ovrflw_o, 0);
        tick();
        send(32'h0BAD_CAFE, 32'h0C0F_FEE0, 1'b1);
        repeat (3) tick();

        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic en;
                    en = ($urandom_range(0, 9) != 0);
                    bus.capture_en_i = en;
                    send(DW'($urandom), DW'($urandom), en);
                    repeat ($urandom_range(3, 6)) tick();
                end
                bus.capture_en_i = 1'b1;
            end
`ifdef SYN_PCM_BUF_CTRL_HOST_RD_EN
            begin
                for (int i = 0; i < 40; i++) begin
                    host_read(8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 8)) tick();
                end
            end
`endif
        join
        repeat (8) tick();

`ifdef SYN_PCM_BUF_CTRL_HOST_RD_EN
        host_read(8'h42);
`endif
        rst = 1'b1;
        resp_q.delete();
        wr_q.delete();
        m_ptr   = 0;
        m_bufs  = 0;
        exp_ovf = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        chk("post_rst_cnt", {bus.buf_cnt_o, bus.buf_sel_o}, 0);
        chk("post_rst_addr", bus.lmem_addr_o, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            send(DW'($urandom), DW'($urandom), 1'b1);
            tick();
        end
        repeat (8) tick();

        chk("wr_q_drained", 64'(wr_q.size()), 0);
        chk("rd_q_drained", 64'(resp_q.size() + req_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
